// File: rtl/page_mux_server_pkg.sv
// Shared types and constants for the page mux server.
package page_mux_server_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT,
    S_LIVE,
    S_HOLD
  } page_srv_state_t;

  localparam int unsigned PAGE_LOOPBACK  = 0;
  localparam int unsigned SEL_FREEZE_BIT = 30;
  localparam int unsigned SEL_ECHO_BIT   = 31;

  function automatic logic [31:0] loopback_word(input logic echo, input logic [15:0] count);
    return {echo, 14'b0, count, 1'b1};
  endfunction

endpackage

// File: rtl/page_mux_server_stale.sv
// Per-page staleness timer: counts idle cycles since the last update, saturating at G_STALE.
module page_stale_timer #(
  parameter int unsigned G_STALE = 40_000_000
) (
  input  logic Clk_ik,
  input  logic Rst_irn,
  input  logic upd_i,
  output logic stale_o
);

  if (G_STALE == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{Clk_ik, Rst_irn, upd_i};
    assign stale_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(G_STALE + 1);
    localparam logic [CW-1:0] LIMIT = CW'(G_STALE);

    logic [CW-1:0] count;

    always_ff @(posedge Clk_ik or negedge Rst_irn) begin
      if (!Rst_irn) begin
        count <= '0;
      end else if (upd_i) begin
        count <= '0;
      end else if (count != LIMIT) begin
        count <= count + CW'(1);
      end
    end

    assign stale_o = (count == LIMIT);
  end

endmodule

// File: rtl/page_mux_server.sv
// Page server: host selector word picks a producer page, presented live or frozen,
// with per-page staleness flags, request counting and invalid-index reporting.
module page_mux_server
  import page_mux_server_pkg::*;
#(
  parameter int unsigned G_PAGES   = 32,
  parameter int unsigned G_WIDTH   = 32,
  parameter int unsigned G_STALE   = 40_000_000,
  parameter logic [31:0] G_DEFAULT = 32'hdeadbeef
) (
  input  logic                       Clk_ik,
  input  logic                       Rst_irn,
  input  logic [31:0]                sel_ib32,
  input  logic                       sel_strobe_i,
  input  logic [G_PAGES*G_WIDTH-1:0] page_data_ib,
  input  logic [G_PAGES-1:0]         page_upd_ib,
  output logic [G_WIDTH-1:0]         data_ob,
  output logic                       data_valid_o,
  output logic [G_PAGES-1:0]         page_stale_ob,
  output logic [15:0]                req_count_ob16,
  output logic                       sel_error_o
);

  localparam int unsigned IW = $clog2(G_PAGES);

  page_srv_state_t state, state_nx;
  logic [7:0]         idx;
  logic               freeze;
  logic               echo;
  logic [G_WIDTH-1:0] pages [G_PAGES];
  logic [G_WIDTH-1:0] page_word;
  logic               idx_bad;
  logic               idx_upd;
  logic               hold_mode;
  logic               present;
  logic               reload;
  logic               valid_nx;
  logic               unused_bits;

  assign unused_bits = ^{sel_ib32[29:8], page_upd_ib[0], page_data_ib[G_WIDTH-1:0]};

  assign pages[0]         = '0;
  assign page_stale_ob[0] = 1'b0;

  for (genvar p = 1; p < G_PAGES; p++) begin : g_page
    assign pages[p] = page_data_ib[p*G_WIDTH +: G_WIDTH];

    page_stale_timer #(.G_STALE(G_STALE)) u_timer (
      .Clk_ik  (Clk_ik),
      .Rst_irn (Rst_irn),
      .upd_i   (page_upd_ib[p]),
      .stale_o (page_stale_ob[p])
    );
  end

  assign idx_bad   = ({1'b0, idx} >= 9'(G_PAGES));
  assign idx_upd   = !idx_bad && (idx != 8'(PAGE_LOOPBACK)) && page_upd_ib[idx[IW-1:0]];
  assign hold_mode = freeze || idx_bad;

  always_comb begin
    page_word = pages[idx[IW-1:0]];
    if (idx_bad) begin
      page_word = G_WIDTH'(G_DEFAULT);
    end else if (idx == 8'(PAGE_LOOPBACK)) begin
      page_word = G_WIDTH'(loopback_word(echo, req_count_ob16));
    end
  end

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) state <= S_IDLE;
    else          state <= state_nx;
  end

  // A new strobe always wins, so it is checked ahead of the per-state transitions.
  always_comb begin
    state_nx = state;
    present  = 1'b0;
    reload   = 1'b0;
    if (sel_strobe_i) begin
      state_nx = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          state_nx = S_PRESENT;
          present  = 1'b1;
        end
        S_PRESENT: begin
          state_nx = hold_mode ? S_HOLD : S_LIVE;
          reload   = !hold_mode;
        end
        S_LIVE:  reload = 1'b1;
        default: ;
      endcase
    end
  end

  assign valid_nx = present || (reload && idx_upd);

  // Selector fields are captured on the strobe edge itself so the page can be
  // loaded at the end of S_LOAD, giving strobe-to-data latency of two cycles.
  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      idx            <= '0;
      freeze         <= 1'b0;
      echo           <= 1'b0;
      req_count_ob16 <= '0;
      data_ob        <= '0;
      data_valid_o   <= 1'b0;
      sel_error_o    <= 1'b0;
    end else begin
      data_valid_o <= valid_nx;
      if (sel_strobe_i) begin
        idx            <= sel_ib32[7:0];
        freeze         <= sel_ib32[SEL_FREEZE_BIT];
        echo           <= sel_ib32[SEL_ECHO_BIT];
        req_count_ob16 <= req_count_ob16 + 16'd1;
      end
      if (present || reload) data_ob <= page_word;
      if (present) sel_error_o <= idx_bad;
    end
  end

endmodule
